ras_ctrl: RTL

- Return-address-stack controller placed directly upstream of the dual-port BRAM that stores spilled stack entries.
- Accepts call (push) and return (pop) events from the branch predictor.
- Keeps the top and next-below entries in registers and uses BRAM port A for spill writes and refill reads.
- Returns the predicted return address one cycle after a pop, with no stall cycles, including back-to-back pops.

---
 rtl/ras_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: top/next-below held in registers, deeper entries spilled to BRAM port A.
// Define RAS_STATS_EN to add saturating overflow/underflow/pop counters.
module ras_ctrl #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_addr,
    input  logic                          pop,
    output logic                          resp_valid,
    output logic [WIDTH-1:0]              resp_addr,
    output logic                          resp_hit,
    output logic [WIDTH-1:0]              top_addr,
    output logic [$clog2(DEPTH+2)-1:0]    count,
    output logic                          mem_re,
    output logic [$clog2(DEPTH)-1:0]      mem_raddr,
    output logic                          mem_we,
    output logic [$clog2(DEPTH)-1:0]      mem_waddr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic [WIDTH-1:0]              mem_rdata
`ifdef RAS_STATS_EN
    ,
    output logic [15:0]                   stat_ovf,
    output logic [15:0]                   stat_unf,
    output logic [31:0]                   stat_pops
`endif
);

    localparam int ADDR = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 2);
    localparam logic [CW-1:0] FULL = CW'(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TAIL = 2'b11
    } op_e;

    op_e              op;
    logic [ADDR-1:0]  ptr;
    logic [WIDTH-1:0] top_q;
    logic [WIDTH-1:0] nxt_q;
    logic             pend;
    logic [WIDTH-1:0] nxt_eff;
    logic             empty;
    logic             refill;

    assign op       = op_e'({pop, push});
    assign empty    = (count == '0);
    assign nxt_eff  = pend ? mem_rdata : nxt_q;
    assign top_addr = top_q;

    // A refill is needed only when a BRAM entry remains below the new next-below slot.
    assign refill = (op == OP_POP) && (count >= CW'(3));

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_re    = 1'b0;
        mem_raddr = ptr - ADDR'(2);
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = top_q;
        if (op == OP_PUSH) begin
            mem_we = 1'b1;
        end else if (refill) begin
            mem_re = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            count      <= '0;
            top_q      <= '0;
            nxt_q      <= '0;
            pend       <= 1'b0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_hit   <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    resp_valid <= 1'b0;
                    nxt_q      <= top_q;
                    top_q      <= push_addr;
                    ptr        <= ptr + ADDR'(1);
                    pend       <= 1'b0;
                    if (count != FULL) count <= count + CW'(1);
                end
                OP_POP: begin
                    resp_valid <= 1'b1;
                    if (!empty) begin
                        resp_addr <= top_q;
                        resp_hit  <= 1'b1;
                        top_q     <= nxt_eff;
                        ptr       <= ptr - ADDR'(1);
                        count     <= count - CW'(1);
                        pend      <= refill;
                    end else begin
                        resp_addr <= '0;
                        resp_hit  <= 1'b0;
                    end
                end
                OP_TAIL: begin
                    // Tail call replaces the top in place; the rest of the stack is untouched.
                    resp_valid <= 1'b1;
                    resp_addr  <= top_q;
                    resp_hit   <= !empty;
                    top_q      <= push_addr;
                    if (empty) count <= CW'(1);
                    if (pend) begin
                        nxt_q <= mem_rdata;
                        pend  <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    if (pend) begin
                        nxt_q <= mem_rdata;
                        pend  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef RAS_STATS_EN
    // Overflow counts only pure pushes at full, the case that discards the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ovf  <= '0;
            stat_unf  <= '0;
            stat_pops <= '0;
        end else begin
            if (op == OP_PUSH && count == FULL && stat_ovf != '1) stat_ovf <= stat_ovf + 16'd1;
            if (pop && empty && stat_unf != '1)                   stat_unf <= stat_unf + 16'd1;
            if (pop && stat_pops != '1)                           stat_pops <= stat_pops + 32'd1;
        end
    end
`endif

endmodule
